// File: rtl/piso_pkg.sv
// ----------------------------------------------------------------------------
// piso_pkg
//   Shared definitions for the parallel-in serial-out serializer.
//   - piso_state_e : FSM state encoding (IDLE, SHIFT, PARITY).
//                    PARITY is reachable only when PISO_PARITY_EN is defined.
//   - cnt_width()  : width of the bit counter for a given word width.
// ----------------------------------------------------------------------------
package piso_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } piso_state_e;

    // The counter runs 0..width-1, so $clog2(width) bits are enough.
    // The floor of 1 keeps the vector legal if this is ever used with width < 2.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_serializer.sv
// ----------------------------------------------------------------------------
// piso_serializer
//   Parallel-in serial-out stage that feeds a downstream SIPO shift register.
//   It accepts a word over a valid/ready handshake and shifts it out one bit
//   per clock. Back-to-back words leave no idle gap in the serial stream.
//
//   Optional feature (macro PISO_PARITY_EN): an even-parity bit follows the
//   last data bit, so a frame is WIDTH+1 cycles. With the macro undefined the
//   parity state and its register do not exist, and a frame is WIDTH cycles.
//
// Parameters
//   WIDTH      parallel word width (>= 2)
//   MSB_FIRST  1: bit WIDTH-1 goes out first, 0: bit 0 goes out first
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active low
//   din          parallel word to serialize
//   din_valid    din holds a word to transfer
//   din_ready    a word can be taken this cycle (does not depend on din_valid)
//   out          serial data bit
//   out_valid    out carries a data or parity bit this cycle
//   frame_start  high during the first bit of each word
//   busy         FSM is not idle
// ----------------------------------------------------------------------------
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             out,
    output logic             out_valid,
    output logic             frame_start,
    output logic             busy
);

    localparam int                 CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);

    piso_state_e      state;
    piso_state_e      state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_shifted;
    logic [CNT_W-1:0] cnt;

    logic             last_data;   // final data bit is on the line
    logic             last_bit;    // final bit of the whole frame is on the line
    logic             xfer;        // handshake completes at the coming edge
    logic             data_bit;

`ifdef PISO_PARITY_EN
    logic             par_r;
`endif

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    assign last_data = (state == SHIFT) && (cnt == CNT_LAST);

`ifdef PISO_PARITY_EN
    assign last_bit  = (state == PARITY);
`else
    assign last_bit  = last_data;
`endif

    // Ready in the last bit lets the next word load on the same edge the
    // current frame ends, which is what keeps the serial stream contiguous.
    assign din_ready = (state == IDLE) || last_bit;
    assign xfer      = din_valid && din_ready;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (xfer) state_nxt = SHIFT;
            end
            SHIFT: begin
                if (last_data) begin
`ifdef PISO_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = xfer ? SHIFT : IDLE;
`endif
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                state_nxt = xfer ? SHIFT : IDLE;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Shift / count datapath
    // ------------------------------------------------------------------
    // Shift toward the output end with zero fill; once a word has fully
    // drained, shreg is all zeros again.
    always_comb begin
        if (MSB_FIRST) begin
            shreg_shifted = {shreg[WIDTH-2:0], 1'b0};
        end else begin
            shreg_shifted = {1'b0, shreg[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (xfer) begin
            shreg <= din;
            cnt   <= '0;
        end else if (state == SHIFT) begin
            shreg <= shreg_shifted;
            // Wrap at the last bit so cnt never leaves 0..WIDTH-1.
            cnt   <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
        end
    end

`ifdef PISO_PARITY_EN
    // Even parity is captured at load time, so din may change afterwards.
    always_ff @(posedge clk) begin
        if (!rst) begin
            par_r <= 1'b0;
        end else if (xfer) begin
            par_r <= ^din;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Outputs: decoded from registered state only
    // ------------------------------------------------------------------
    assign data_bit = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];

    always_comb begin
        out = 1'b0;
        if (state == SHIFT) begin
            out = data_bit;
        end
`ifdef PISO_PARITY_EN
        else if (state == PARITY) begin
            out = par_r;
        end
`endif
    end

    assign out_valid   = (state != IDLE);
    assign frame_start = (state == SHIFT) && (cnt == '0);
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_piso_serializer.sv
// ----------------------------------------------------------------------------
// tb_piso_serializer
//   Directed bench for piso_serializer. u_msb is WIDTH=4 MSB-first, u_lsb is
//   WIDTH=4 LSB-first. A 4-bit SIPO model follows u_msb's serial line.
//   Inputs change and outputs are sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
    localparam int             FR       = 5;
    // 1011 + parity 1, 0110 + parity 0
    localparam logic [9:0]     B2B_BITS = 10'b10111_01100;
    // 1100 + parity 0, 1111 + parity 0
    localparam logic [9:0]     STL_BITS = 10'b11000_11110;
    // 0001 LSB-first -> 1,0,0,0 then parity 1
    localparam logic [4:0]     LSB_BITS = 5'b10001;
    // SIPO sees 1,0,1,1,1 and keeps the last four
    localparam logic [3:0]     SIPO_EXP = 4'b0111;
`else
    localparam int             FR       = 4;
    localparam logic [9:0]     B2B_BITS = 10'b1011_0110_00;
    localparam logic [9:0]     STL_BITS = 10'b1100_1111_00;
    localparam logic [4:0]     LSB_BITS = 5'b1000_0;
    localparam logic [3:0]     SIPO_EXP = 4'b1011;
`endif

    logic       clk;
    logic       rst;
    logic [3:0] din0, din1;
    logic       vld0, vld1;
    logic       rdy0, rdy1;
    logic       out0, out1;
    logic       ov0, ov1;
    logic       fs0, fs1;
    logic       busy0, busy1;
    logic [3:0] sipo_d;

    int checks   = 0;
    int failures = 0;

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .din(din0), .din_valid(vld0), .din_ready(rdy0),
        .out(out0), .out_valid(ov0), .frame_start(fs0), .busy(busy0)
    );

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .din(din1), .din_valid(vld1), .din_ready(rdy1),
        .out(out1), .out_valid(ov1), .frame_start(fs1), .busy(busy1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Downstream SIPO: samples the serial line on the same edge.
    always_ff @(posedge clk) begin
        if (!rst) sipo_d <= '0;
        else if (ov0) sipo_d <= {sipo_d[2:0], out0};
    end

    task automatic test_reset();
        rst  = 1'b0;
        din0 = 4'b1111; vld0 = 1'b1;
        din1 = 4'b1111; vld1 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({out0, ov0, rdy0, busy0, fs0} !== 5'b00100) begin
            failures++;
            $display("FAIL reset_msb got out/ov/rdy/busy/fs=%b want 00100",
                     {out0, ov0, rdy0, busy0, fs0});
        end
        checks++;
        if ({out1, ov1, rdy1, busy1, fs1} !== 5'b00100) begin
            failures++;
            $display("FAIL reset_lsb got out/ov/rdy/busy/fs=%b want 00100",
                     {out1, ov1, rdy1, busy1, fs1});
        end
        rst = 1'b1; vld0 = 1'b0; vld1 = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy0, busy1, ov0} !== 3'b000) begin
            failures++;
            $display("FAIL reset_no_xfer got busy0/busy1/ov0=%b want 000", {busy0, busy1, ov0});
        end
    endtask

    task automatic test_single();
        logic [3:0] w = 4'b1011;
        checks++;
        if (rdy0 !== 1'b1) begin
            failures++;
            $display("FAIL single_idle_ready got %b want 1", rdy0);
        end
        din0 = w; vld0 = 1'b1;
        @(negedge clk);
        vld0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({out0, ov0, fs0, busy0, rdy0} !==
                {w[3-i], 1'b1, (i == 0), 1'b1, (i == 3 && FR == 4)}) begin
                failures++;
                $display("FAIL single_bit%0d got out/ov/fs/busy/rdy=%b want %b", i,
                         {out0, ov0, fs0, busy0, rdy0},
                         {w[3-i], 1'b1, (i == 0), 1'b1, (i == 3 && FR == 4)});
            end
            @(negedge clk);
        end
        if (FR == 5) begin
            checks++;
            if ({out0, ov0, fs0, rdy0} !== 4'b1101) begin
                failures++;
                $display("FAIL single_parity got out/ov/fs/rdy=%b want 1101",
                         {out0, ov0, fs0, rdy0});
            end
            @(negedge clk);
        end
        checks++;
        if ({busy0, ov0, out0} !== 3'b000) begin
            failures++;
            $display("FAIL single_end got busy/ov/out=%b want 000", {busy0, ov0, out0});
        end
        checks++;
        if (sipo_d !== SIPO_EXP) begin
            failures++;
            $display("FAIL single_sipo got %b want %b", sipo_d, SIPO_EXP);
        end
    endtask

    task automatic test_back_to_back();
        din0 = 4'b1011; vld0 = 1'b1;
        @(negedge clk);
        din0 = 4'b0110;
        for (int i = 0; i < 2 * FR; i++) begin
            if (i == FR) vld0 = 1'b0;
            checks++;
            if ({out0, ov0, fs0} !== {B2B_BITS[9-i], 1'b1, (i % FR == 0)}) begin
                failures++;
                $display("FAIL b2b_bit%0d got out/ov/fs=%b want %b", i, {out0, ov0, fs0},
                         {B2B_BITS[9-i], 1'b1, (i % FR == 0)});
            end
            @(negedge clk);
        end
        checks++;
        if ({ov0, busy0} !== 2'b00) begin
            failures++;
            $display("FAIL b2b_end got ov/busy=%b want 00", {ov0, busy0});
        end
    endtask

    task automatic test_stall();
        din0 = 4'b1100; vld0 = 1'b1;
        @(negedge clk);
        vld0 = 1'b0;
        for (int i = 0; i < 2 * FR; i++) begin
            if (i == 1) begin
                din0 = 4'b1111; vld0 = 1'b1;
            end
            if (i == FR) vld0 = 1'b0;
            checks++;
            if ({out0, ov0, rdy0} !== {STL_BITS[9-i], 1'b1, (i % FR == FR - 1)}) begin
                failures++;
                $display("FAIL stall_bit%0d got out/ov/rdy=%b want %b", i, {out0, ov0, rdy0},
                         {STL_BITS[9-i], 1'b1, (i % FR == FR - 1)});
            end
            @(negedge clk);
        end
        checks++;
        if ({ov0, busy0} !== 2'b00) begin
            failures++;
            $display("FAIL stall_end got ov/busy=%b want 00", {ov0, busy0});
        end
    endtask

    task automatic test_midreset();
        logic [3:0] w = 4'b1010;
        din0 = w; vld0 = 1'b1;
        @(negedge clk);
        vld0 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({out0, ov0} !== {w[3-i], 1'b1}) begin
                failures++;
                $display("FAIL midrst_bit%0d got out/ov=%b want %b", i, {out0, ov0}, {w[3-i], 1'b1});
            end
            @(negedge clk);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({out0, ov0, busy0, rdy0} !== 4'b0001) begin
            failures++;
            $display("FAIL midrst_abort got out/ov/busy/rdy=%b want 0001",
                     {out0, ov0, busy0, rdy0});
        end
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({out0, ov0, busy0} !== 3'b000) begin
                failures++;
                $display("FAIL midrst_no_resume%0d got out/ov/busy=%b want 000", i,
                         {out0, ov0, busy0});
            end
        end
    endtask

    task automatic test_lsb_first();
        din1 = 4'b0001; vld1 = 1'b1;
        @(negedge clk);
        vld1 = 1'b0;
        for (int i = 0; i < FR; i++) begin
            checks++;
            if ({out1, ov1, fs1} !== {LSB_BITS[4-i], 1'b1, (i == 0)}) begin
                failures++;
                $display("FAIL lsb_bit%0d got out/ov/fs=%b want %b", i, {out1, ov1, fs1},
                         {LSB_BITS[4-i], 1'b1, (i == 0)});
            end
            @(negedge clk);
        end
        checks++;
        if ({ov1, busy1, ov0} !== 3'b000) begin
            failures++;
            $display("FAIL lsb_end got ov1/busy1/ov0=%b want 000", {ov1, busy1, ov0});
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_midreset();
        test_lsb_first();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
